// File: rtl/lcd_cmd_sequencer_if.sv
// Bus between the command sequencer, the command ROM and LCD_CTRL.
// Handshake: cmd_valid is a one-cycle strobe that carries cmd; it is only raised
// when busy was sampled low, LCD_CTRL raises busy the cycle after the strobe and
// drops it when ready for the next command. done is a one-cycle pulse from LCD_CTRL.
// The ROM is read by holding CMD_EN low for one cycle; CMD_Q is valid the cycle after.
interface lcd_cmd_sequencer_if #(
   parameter int AW = 6
) ();
   logic          start;
   logic          CMD_EN;
   logic [AW-1:0] CMD_A;
   logic [2:0]    CMD_Q;
   logic [2:0]    cmd;
   logic          cmd_valid;
   logic          busy;
   logic          done;
   logic          seq_busy;
   logic          seq_done;
   logic [1:0]    seq_err;
   logic [AW-1:0] cmd_count;
   logic [2:0]    state_dbg;

   modport master (
      input  start, CMD_Q, busy, done,
      output CMD_EN, CMD_A, cmd, cmd_valid, seq_busy, seq_done, seq_err, cmd_count,
             state_dbg
   );

   modport slave (
      output start, CMD_Q, busy, done,
      input  CMD_EN, CMD_A, cmd, cmd_valid, seq_busy, seq_done, seq_err, cmd_count,
             state_dbg
   );
endinterface

// File: rtl/lcd_cmd_sequencer.sv
// Replays a stored command list from a synchronous ROM into LCD_CTRL, one command
// per busy handshake, and stops after the write command once LCD_CTRL reports done.
// Every output is a register; the combinational process computes next values only.
module lcd_cmd_sequencer #(
   parameter int CMD_DEPTH = 45,
   parameter int AW        = 6,
   parameter int TIMEOUT   = 1024
) (
   input  logic                clk,
   input  logic                reset,
   lcd_cmd_sequencer_if.master bus
);
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [AW-1:0] LAST_ADDR  = AW'(CMD_DEPTH - 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT_Q, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_FINISH, S_ERR
   } state_t;

   state_t        state, state_n;
   logic          en_q, en_n;
   logic [AW-1:0] addr_q, addr_n;
   logic [2:0]    cmd_q, cmd_n;
   logic          valid_q, valid_n;
   logic          sbusy_q, sbusy_n;
   logic          sdone_q, sdone_n;
   logic [1:0]    err_q, err_n;
   logic [AW-1:0] count_q, count_n;
   logic          settle_q, settle_n;
   logic [TW-1:0] timer_q, timer_n;
   logic          timer_hit;

   assign timer_hit = (timer_q == TIMER_LAST);

   // State and output registers; reset wins over any in-flight command.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         en_q     <= 1'b1;
         addr_q   <= '0;
         cmd_q    <= '0;
         valid_q  <= 1'b0;
         sbusy_q  <= 1'b0;
         sdone_q  <= 1'b0;
         err_q    <= '0;
         count_q  <= '0;
         settle_q <= 1'b0;
         timer_q  <= '0;
      end else begin
         state    <= state_n;
         en_q     <= en_n;
         addr_q   <= addr_n;
         cmd_q    <= cmd_n;
         valid_q  <= valid_n;
         sbusy_q  <= sbusy_n;
         sdone_q  <= sdone_n;
         err_q    <= err_n;
         count_q  <= count_n;
         settle_q <= settle_n;
         timer_q  <= timer_n;
      end
   end

   // Next-state and next-output logic; the timer restarts on every state change.
   always_comb begin
      state_n  = state;
      en_n     = 1'b1;
      addr_n   = addr_q;
      cmd_n    = cmd_q;
      valid_n  = 1'b0;
      sbusy_n  = sbusy_q;
      sdone_n  = 1'b0;
      err_n    = err_q;
      count_n  = count_q;
      settle_n = 1'b0;
      timer_n  = timer_q;

      case (state)
         S_IDLE, S_ERR: begin
            if (bus.start) begin
               state_n = S_FETCH;
               en_n    = 1'b0;
               addr_n  = '0;
               count_n = '0;
               err_n   = 2'd0;
               sbusy_n = 1'b1;
            end
         end
         S_FETCH: state_n = S_WAIT_Q;
         S_WAIT_Q: begin
            cmd_n   = bus.CMD_Q;
            state_n = S_ISSUE;
         end
         S_ISSUE: begin
            // Timeout beats a busy fall seen in the same cycle.
            if (timer_hit) begin
               err_n   = 2'd2;
               sbusy_n = 1'b0;
               state_n = S_ERR;
            end else if (bus.busy) begin
               timer_n = timer_q + 1'b1;
            end else begin
               valid_n  = 1'b1;
               count_n  = (count_q == '1) ? count_q : count_q + 1'b1;
               settle_n = 1'b1;
               state_n  = S_WAIT_BUSY;
            end
         end
         S_WAIT_BUSY: begin
            // The strobe cycle itself is skipped: LCD_CTRL has not raised busy yet.
            if (!settle_q) begin
               if (timer_hit) begin
                  err_n   = 2'd2;
                  sbusy_n = 1'b0;
                  state_n = S_ERR;
               end else if (bus.busy) begin
                  timer_n = timer_q + 1'b1;
               end else if (cmd_q == 3'd0) begin
                  state_n = S_WAIT_DONE;
               end else if (addr_q == LAST_ADDR) begin
                  err_n   = 2'd1;
                  sbusy_n = 1'b0;
                  state_n = S_ERR;
               end else begin
                  addr_n  = addr_q + 1'b1;
                  en_n    = 1'b0;
                  state_n = S_FETCH;
               end
            end
         end
         S_WAIT_DONE: begin
            if (timer_hit) begin
               err_n   = 2'd2;
               sbusy_n = 1'b0;
               state_n = S_ERR;
            end else if (bus.done) begin
               sdone_n = 1'b1;
               sbusy_n = 1'b0;
               state_n = S_FINISH;
            end else begin
               timer_n = timer_q + 1'b1;
            end
         end
         S_FINISH: state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase

      if (state_n != state) timer_n = '0;
   end

   assign bus.CMD_EN    = en_q;
   assign bus.CMD_A     = addr_q;
   assign bus.cmd       = cmd_q;
   assign bus.cmd_valid = valid_q;
   assign bus.seq_busy  = sbusy_q;
   assign bus.seq_done  = sdone_q;
   assign bus.seq_err   = err_q;
   assign bus.cmd_count = count_q;
   assign bus.state_dbg = state;
endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Directed bench for lcd_cmd_sequencer: a main instance (TIMEOUT=1024) and a second
// instance with TIMEOUT=16 for the stuck-busy case. Each has a ROM model and an
// LCD_CTRL responder (busy high two cycles after each strobe; for the write command,
// done two cycles after busy falls).
module tb_lcd_cmd_sequencer;
   localparam int AW = 6;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_ISSUE     = 3'd3;
   localparam logic [2:0] ST_WAIT_BUSY = 3'd4;
   localparam logic [2:0] ST_ERR       = 3'd7;

   logic clk;
   logic rst;
   logic rst2;

   lcd_cmd_sequencer_if #(.AW(AW)) bus ();
   lcd_cmd_sequencer_if #(.AW(AW)) bus2 ();

   lcd_cmd_sequencer #(.CMD_DEPTH(45), .AW(AW), .TIMEOUT(1024)) u_dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   lcd_cmd_sequencer #(.CMD_DEPTH(45), .AW(AW), .TIMEOUT(16)) u_dut_to (
      .clk   (clk),
      .reset (rst2),
      .bus   (bus2)
   );

   logic [2:0] rom  [0:63];
   logic [2:0] rom2 [0:63];

   int n_checks = 0;
   int n_errors = 0;

   logic [2:0] obs_q[$];
   int         t_q[$];
   logic [2:0] exp_q[$];
   int         cyc = 0;
   int         done_pulses = 0;
   int         viol = 0;
   logic       force_busy = 1'b0;
   int         bcnt = 0;
   int         dcnt = 0;
   int         b2 = 0;
   int         nval2 = 0;
   logic       stuck2 = 1'b0;
   int         n;

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog
   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ROM models: data appears the cycle after CMD_EN is sampled low
   initial begin
      bus.CMD_Q = 3'd0;
      forever begin
         @(posedge clk);
         if (!bus.CMD_EN) bus.CMD_Q <= rom[bus.CMD_A];
      end
   end

   initial begin
      bus2.CMD_Q = 3'd0;
      forever begin
         @(posedge clk);
         if (!bus2.CMD_EN) bus2.CMD_Q <= rom2[bus2.CMD_A];
      end
   end

   // LCD_CTRL responder for the main instance
   initial begin
      bus.busy = 1'b0;
      bus.done = 1'b0;
      forever begin
         @(negedge clk);
         bus.busy = force_busy || (bcnt != 0);
         if (bcnt != 0) bcnt--;
         bus.done = (dcnt == 1);
         if (dcnt != 0) dcnt--;
         if (bus.cmd_valid) begin
            bcnt = 2;
            if (bus.cmd == 3'd0) dcnt = 5;
         end
      end
   end

   // LCD_CTRL responder for the timeout instance: busy sticks after the second strobe
   initial begin
      bus2.busy = 1'b0;
      bus2.done = 1'b0;
      forever begin
         @(negedge clk);
         bus2.busy = stuck2 || (b2 != 0);
         if (b2 != 0) b2--;
         if (bus2.cmd_valid) begin
            nval2++;
            b2 = 2;
            if (nval2 == 2) stuck2 = 1'b1;
         end
      end
   end

   // Monitor: records every issued command and its cycle, counts seq_done pulses
   initial begin
      forever begin
         @(negedge clk);
         #1;
         cyc++;
         if (bus.cmd_valid) begin
            obs_q.push_back(bus.cmd);
            t_q.push_back(cyc);
            if (bus.busy) viol++;
         end
         if (bus.seq_done) done_pulses++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_sb();
      obs_q.delete();
      t_q.delete();
      done_pulses = 0;
      viol = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      clear_sb();
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int bound);
      int k;
      k = 0;
      while (bus.seq_busy && k < bound) begin
         tick();
         k++;
      end
      check({tag, "_ended"}, bus.seq_busy, 0);
      repeat (3) tick();
   endtask

   task automatic wait_issues(input string tag, input int cnt, input int bound);
      int k;
      k = 0;
      while (obs_q.size() < cnt && k < bound) begin
         tick();
         k++;
      end
      check({tag, "_issued"}, obs_q.size() >= cnt, 1);
   endtask

   task automatic compare_seq(input string tag);
      int i;
      check({tag, "_nissue"}, obs_q.size(), exp_q.size());
      i = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         check($sformatf("%s_cmd%0d", tag, i), obs_q.pop_front(), exp_q.pop_front());
         i++;
      end
   endtask

   task automatic load_basic();
      for (int i = 0; i < 64; i++) rom[i] = 3'd0;
      rom[0] = 3'd1;
      rom[1] = 3'd3;
      rom[2] = 3'd5;
      rom[3] = 3'd0;
   endtask

   // Main sequence
   initial begin
      rst = 1'b1;
      rst2 = 1'b1;
      bus.start = 1'b0;
      bus2.start = 1'b0;
      for (int i = 0; i < 64; i++) rom2[i] = 3'd0;
      rom2[0] = 3'd2;
      rom2[1] = 3'd6;
      rom2[2] = 3'd7;
      load_basic();
      repeat (3) tick();

      // Reset values
      check("rst_cmd_en", bus.CMD_EN, 1);
      check("rst_cmd_a", bus.CMD_A, 0);
      check("rst_cmd", bus.cmd, 0);
      check("rst_cmd_valid", bus.cmd_valid, 0);
      check("rst_seq_busy", bus.seq_busy, 0);
      check("rst_seq_done", bus.seq_done, 0);
      check("rst_seq_err", bus.seq_err, 0);
      check("rst_cmd_count", bus.cmd_count, 0);
      check("rst_state", bus.state_dbg, ST_IDLE);
      rst = 1'b0;
      tick();
      clear_sb();

      // Basic list 1,3,5,0
      pulse_start();
      check("t1_seq_busy", bus.seq_busy, 1);
      n = 0;
      while (!bus.cmd_valid && n < 20) begin
         tick();
         n++;
      end
      check("t1_start_to_valid", n, 3);
      wait_idle("t1", 200);
      check("t1_gap", (t_q.size() >= 2) ? t_q[1] - t_q[0] : 0, 7);
      exp_q = '{3'd1, 3'd3, 3'd5, 3'd0};
      compare_seq("t1");
      check("t1_count", bus.cmd_count, 4);
      check("t1_done_pulses", done_pulses, 1);
      check("t1_err", bus.seq_err, 0);
      check("t1_viol", viol, 0);

      // Image load: busy high for 50 cycles while the first command waits
      force_busy = 1'b1;
      do_reset();
      pulse_start();
      repeat (50) tick();
      check("t2_no_issue_during_load", obs_q.size(), 0);
      check("t2_state_issue", bus.state_dbg, ST_ISSUE);
      force_busy = 1'b0;
      n = 0;
      while (!bus.cmd_valid && n < 20) begin
         tick();
         n++;
      end
      check("t2_fall_to_valid", n, 2);
      wait_idle("t2", 200);
      exp_q = '{3'd1, 3'd3, 3'd5, 3'd0};
      compare_seq("t2");
      check("t2_done_pulses", done_pulses, 1);
      check("t2_viol", viol, 0);

      // 45 entries without a write command
      for (int i = 0; i < 64; i++) rom[i] = (i < 45) ? 3'd4 : 3'd0;
      do_reset();
      pulse_start();
      wait_idle("t3", 600);
      check("t3_nissue", obs_q.size(), 45);
      check("t3_cmd_a", bus.CMD_A, 44);
      check("t3_err", bus.seq_err, 1);
      check("t3_count", bus.cmd_count, 45);
      check("t3_state", bus.state_dbg, ST_ERR);
      check("t3_done_pulses", done_pulses, 0);
      check("t3_viol", viol, 0);

      // Restart from the error state clears seq_err
      load_basic();
      clear_sb();
      pulse_start();
      check("t3r_err_cleared", bus.seq_err, 0);
      check("t3r_cmd_a", bus.CMD_A, 0);
      wait_idle("t3r", 200);
      exp_q = '{3'd1, 3'd3, 3'd5, 3'd0};
      compare_seq("t3r");
      check("t3r_done_pulses", done_pulses, 1);

      // Timeout instance: busy stuck after the second issue
      rst2 = 1'b0;
      tick();
      bus2.start = 1'b1;
      tick();
      bus2.start = 1'b0;
      n = 0;
      while (nval2 < 2 && n < 100) begin
         tick();
         n++;
      end
      check("t4_second_issue", nval2, 2);
      n = 0;
      while (bus2.seq_err != 2'd2 && n < 100) begin
         tick();
         n++;
      end
      check("t4_strobe_to_err", n, 17);
      check("t4_seq_busy", bus2.seq_busy, 0);
      check("t4_state", bus2.state_dbg, ST_ERR);
      repeat (10) tick();
      check("t4_no_more_issue", nval2, 2);
      check("t4_count", bus2.cmd_count, 2);
      check("t4_err_held", bus2.seq_err, 2);

      // Reset in WAIT_BUSY of the third command
      do_reset();
      pulse_start();
      wait_issues("t5", 3, 100);
      check("t5_in_wait_busy", bus.state_dbg, ST_WAIT_BUSY);
      rst = 1'b1;
      tick();
      check("t5_rst_state", bus.state_dbg, ST_IDLE);
      check("t5_rst_cmd_en", bus.CMD_EN, 1);
      check("t5_rst_cmd_a", bus.CMD_A, 0);
      check("t5_rst_cmd", bus.cmd, 0);
      check("t5_rst_valid", bus.cmd_valid, 0);
      check("t5_rst_seq_busy", bus.seq_busy, 0);
      check("t5_rst_count", bus.cmd_count, 0);
      rst = 1'b0;
      repeat (3) tick();
      clear_sb();
      pulse_start();
      wait_idle("t5", 200);
      exp_q = '{3'd1, 3'd3, 3'd5, 3'd0};
      compare_seq("t5");
      check("t5_done_pulses", done_pulses, 1);

      // Mid-sequence start and a spurious done while waiting to issue
      do_reset();
      pulse_start();
      wait_issues("t6", 1, 50);
      pulse_start();
      n = 0;
      while (bus.state_dbg != ST_ISSUE && n < 30) begin
         tick();
         n++;
      end
      check("t6_reached_issue", bus.state_dbg, ST_ISSUE);
      bus.done = 1'b1;
      wait_idle("t6", 200);
      repeat (20) tick();
      exp_q = '{3'd1, 3'd3, 3'd5, 3'd0};
      compare_seq("t6");
      check("t6_done_pulses", done_pulses, 1);
      check("t6_count", bus.cmd_count, 4);
      check("t6_seq_busy", bus.seq_busy, 0);
      check("t6_err", bus.seq_err, 0);
      check("t6_viol", viol, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
